multicycle_ctrl: RTL

Multi-cycle sequencer for the simple RISC-V core. Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB for each instruction. Drives instruction and data ROM request handshakes, ALU control and register/PC enables. Flags illegal opcodes and memory timeouts as sticky faults.

---
 rtl/multicycle_ctrl_pkg.sv | 44 ++++
 rtl/multicycle_ctrl_if.sv | 44 ++++
 rtl/multicycle_ctrl_decode.sv | 31 +++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl_pkg : opcodes, ALU encodings, states and fault codes     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package multicycle_ctrl_pkg;

  localparam logic [6:0] c_OP_ADD  = 7'b0110011;
  localparam logic [6:0] c_OP_ADDI = 7'b0010011;
  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
  localparam logic [6:0] c_OP_HALT = 7'b1110011;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_NOP = 3'b111;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_FETCH  = 3'd1;
  localparam logic [2:0] c_ST_DECODE = 3'd2;
  localparam logic [2:0] c_ST_EXEC   = 3'd3;
  localparam logic [2:0] c_ST_MEM    = 3'd4;
  localparam logic [2:0] c_ST_WB     = 3'd5;
  localparam logic [2:0] c_ST_HALT   = 3'd6;
  localparam logic [2:0] c_ST_FAULT  = 3'd7;

  localparam logic [1:0] c_FC_NONE    = 2'b00;
  localparam logic [1:0] c_FC_ILLEGAL = 2'b01;
  localparam logic [1:0] c_FC_IMEM    = 2'b10;
  localparam logic [1:0] c_FC_DMEM    = 2'b11;

  typedef enum logic [2:0] {
    CLS_ADD,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_HALT,
    CLS_ILL
  } instr_class_e;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl_if : controller <-> datapath/memory handshake bundle     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface multicycle_ctrl_if #(
  parameter int RET_W = 32
);
  logic             start;
  logic [6:0]       opcode;
  logic             alu_zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_en;
  logic             dmem_req;
  logic             data_rom_write_en;
  logic [2:0]       ALU_CTL;
  logic             alu_src_imm;
  logic             wb_sel_mem;
  logic             reg_write_en;
  logic             pc_en;
  logic             pc_src_branch;
  logic             busy;
  logic             halted;
  logic             fault;
  logic [1:0]       fault_code;
  logic [RET_W-1:0] retired;

  modport master (
    input  start, opcode, alu_zero, imem_ready, dmem_ready,
    output imem_req, ir_en, dmem_req, data_rom_write_en, ALU_CTL, alu_src_imm,
           wb_sel_mem, reg_write_en, pc_en, pc_src_branch, busy, halted, fault,
           fault_code, retired
  );

  modport slave (
    output start, opcode, alu_zero, imem_ready, dmem_ready,
    input  imem_req, ir_en, dmem_req, data_rom_write_en, ALU_CTL, alu_src_imm,
           wb_sel_mem, reg_write_en, pc_en, pc_src_branch, busy, halted, fault,
           fault_code, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_decode : opcode -> instruction class, illegal flag, EXEC ALU_CTL    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]   i_opcode,
  output instr_class_e o_cls,
  output logic         o_illegal,
  output logic [2:0]   o_alu_ctl
);

  always_comb begin
    o_cls     = CLS_ILL;
    o_illegal = 1'b0;
    o_alu_ctl = c_ALU_NOP;
    case (i_opcode)
      c_OP_ADD:  begin o_cls = CLS_ADD;  o_alu_ctl = c_ALU_ADD; end
      c_OP_ADDI: begin o_cls = CLS_ADDI; o_alu_ctl = c_ALU_ADD; end
      c_OP_LW:   begin o_cls = CLS_LW;   o_alu_ctl = c_ALU_ADD; end
      c_OP_SW:   begin o_cls = CLS_SW;   o_alu_ctl = c_ALU_ADD; end
      c_OP_BEQ:  begin o_cls = CLS_BEQ;  o_alu_ctl = c_ALU_SUB; end
      c_OP_HALT: begin o_cls = CLS_HALT; end
      default:   begin o_illegal = 1'b1; end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_ctrl : FETCH/DECODE/EXEC/MEM/WB sequencer with sticky faults  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RET_W       = 32
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [7:0] c_MEM_TIMEOUT = 8'(MEM_TIMEOUT);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  instr_class_e     r_cls;
  instr_class_e     w_dec_cls;
  logic [2:0]       r_exec_alu;
  logic [2:0]       w_dec_alu;
  logic             w_dec_illegal;
  logic [7:0]       r_wait;
  logic [7:0]       w_wait_inc;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_fault_code_next;
  logic [RET_W-1:0] r_retired;
  logic             w_ready;
  logic             w_timeout;

  logic             w_imem_req;
  logic             w_ir_en;
  logic             w_dmem_req;
  logic             w_dwe;
  logic [2:0]       w_alu_ctl;
  logic             w_alu_src_imm;
  logic             w_wb_sel_mem;
  logic             w_reg_write_en;
  logic             w_pc_en;
  logic             w_pc_src_branch;

  ctrl_decode u_decode (
    .i_opcode  (bus.opcode),
    .o_cls     (w_dec_cls),
    .o_illegal (w_dec_illegal),
    .o_alu_ctl (w_dec_alu)
  );

  // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT;
  // a ready in that same cycle wins.
  assign w_ready    = (r_state == c_ST_FETCH) ? bus.imem_ready : bus.dmem_ready;
  assign w_wait_inc = r_wait + 8'd1;
  assign w_timeout  = !w_ready && (w_wait_inc == c_MEM_TIMEOUT);

  always_comb begin
    w_state_next      = r_state;
    w_fault_code_next = r_fault_code;
    case (r_state)
      c_ST_IDLE: if (bus.start) w_state_next = c_ST_FETCH;
      c_ST_FETCH: begin
        if (bus.imem_ready) begin
          w_state_next = c_ST_DECODE;
        end else if (w_timeout) begin
          w_state_next      = c_ST_FAULT;
          w_fault_code_next = c_FC_IMEM;
        end
      end
      c_ST_DECODE: begin
        if (w_dec_illegal) begin
          w_state_next      = c_ST_FAULT;
          w_fault_code_next = c_FC_ILLEGAL;
        end else begin
          w_state_next = c_ST_EXEC;
        end
      end
      c_ST_EXEC: begin
        case (r_cls)
          CLS_ADD, CLS_ADDI: w_state_next = c_ST_WB;
          CLS_LW, CLS_SW:    w_state_next = c_ST_MEM;
          CLS_BEQ:           w_state_next = c_ST_FETCH;
          CLS_HALT:          w_state_next = c_ST_HALT;
          default: begin
            w_state_next      = c_ST_FAULT;
            w_fault_code_next = c_FC_ILLEGAL;
          end
        endcase
      end
      c_ST_MEM: begin
        if (bus.dmem_ready) begin
          w_state_next = (r_cls == CLS_SW) ? c_ST_FETCH : c_ST_WB;
        end else if (w_timeout) begin
          w_state_next      = c_ST_FAULT;
          w_fault_code_next = c_FC_DMEM;
        end
      end
      c_ST_WB:    w_state_next = c_ST_FETCH;
      c_ST_HALT:  w_state_next = c_ST_HALT;
      c_ST_FAULT: w_state_next = c_ST_FAULT;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_ST_IDLE;
      r_cls        <= CLS_ILL;
      r_exec_alu   <= c_ALU_NOP;
      r_wait       <= 8'd0;
      r_fault_code <= c_FC_NONE;
      r_retired    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fault_code <= w_fault_code_next;
      if (r_state == c_ST_DECODE) begin
        r_cls      <= w_dec_cls;
        r_exec_alu <= w_dec_alu;
      end
      if (w_state_next != r_state) begin
        r_wait <= 8'd0;
      end else if ((r_state == c_ST_FETCH || r_state == c_ST_MEM) && !w_ready) begin
        r_wait <= w_wait_inc;
      end
      if (w_pc_en) r_retired <= r_retired + RET_W'(1);
    end
  end

  always_comb begin
    w_imem_req      = 1'b0;
    w_ir_en         = 1'b0;
    w_dmem_req      = 1'b0;
    w_dwe           = 1'b0;
    w_alu_ctl       = c_ALU_NOP;
    w_alu_src_imm   = 1'b0;
    w_wb_sel_mem    = 1'b0;
    w_reg_write_en  = 1'b0;
    w_pc_en         = 1'b0;
    w_pc_src_branch = 1'b0;
    case (r_state)
      c_ST_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_en    = bus.imem_ready;
      end
      c_ST_EXEC: begin
        w_alu_ctl     = r_exec_alu;
        w_alu_src_imm = (r_cls == CLS_ADDI) || (r_cls == CLS_LW) || (r_cls == CLS_SW);
        if (r_cls == CLS_BEQ) begin
          w_pc_en         = 1'b1;
          w_pc_src_branch = bus.alu_zero;
        end
      end
      c_ST_MEM: begin
        w_dmem_req = 1'b1;
        if (r_cls == CLS_SW) begin
          w_dwe     = 1'b1;
          w_alu_ctl = c_ALU_ADD;
          w_pc_en   = bus.dmem_ready;
        end
      end
      c_ST_WB: begin
        w_reg_write_en = 1'b1;
        w_pc_en        = 1'b1;
        w_wb_sel_mem   = (r_cls == CLS_LW);
      end
      default: ;
    endcase
  end

  assign bus.imem_req          = w_imem_req;
  assign bus.ir_en             = w_ir_en;
  assign bus.dmem_req          = w_dmem_req;
  assign bus.data_rom_write_en = w_dwe;
  assign bus.ALU_CTL           = w_alu_ctl;
  assign bus.alu_src_imm       = w_alu_src_imm;
  assign bus.wb_sel_mem        = w_wb_sel_mem;
  assign bus.reg_write_en      = w_reg_write_en;
  assign bus.pc_en             = w_pc_en;
  assign bus.pc_src_branch     = w_pc_src_branch;
  assign bus.busy              = (r_state != c_ST_IDLE) && (r_state != c_ST_HALT) &&
                                 (r_state != c_ST_FAULT);
  assign bus.halted            = (r_state == c_ST_HALT);
  assign bus.fault             = (r_state == c_ST_FAULT);
  assign bus.fault_code        = r_fault_code;
  assign bus.retired           = r_retired;

endmodule
`default_nettype wire
